// File: rtl/mem_resp_pkg.sv
// Shared sizing defaults and FSM state encoding for the cache-line memory responder.
package mem_resp_pkg;

    localparam int LINE_ADDR_W = 13;
    localparam int WORDS       = 16;
    localparam int DATA_W      = 32;
    localparam int BEAT_W      = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_WAIT,
        WR_ACK,
        RD_WAIT,
        RD_BURST
    } state_t;

endpackage

// File: rtl/line_mem_responder_line_store.sv
// Backing store indexed by {line, beat}: one synchronous write port and one
// registered read port whose output register holds its value until the next read enable.
module line_store
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = mem_resp_pkg::LINE_ADDR_W + mem_resp_pkg::BEAT_W,
    parameter int WORD_W = mem_resp_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [0:(1 << ADDR_W) - 1];
    logic [WORD_W-1:0] r_rd_data;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory responder: whole-line refill bursts and write-backs with a
// programmable access latency, in front of the line_store array.
module line_mem_responder #(
    parameter int LINE_ADDR_W = mem_resp_pkg::LINE_ADDR_W,
    parameter int WORDS       = mem_resp_pkg::WORDS,
    parameter int DATA_W      = mem_resp_pkg::DATA_W,
    parameter int LATENCY     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_write,
    input  logic [LINE_ADDR_W-1:0] i_req_line,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic                   o_wr_ack,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_rd_last
);
    import mem_resp_pkg::*;

    // state    | meaning
    // IDLE     | waiting for a request
    // WR_DATA  | collecting write-back beats
    // WR_WAIT  | access latency before the write ack
    // WR_ACK   | one-cycle write-back committed pulse
    // RD_WAIT  | access latency before the first refill beat
    // RD_BURST | presenting refill beats

    localparam int                LBW       = $clog2(WORDS);
    localparam int                ADDR_W    = LINE_ADDR_W + LBW;
    localparam logic [3:0]        LAT_LOAD  = 4'(LATENCY - 1);
    localparam logic [LBW-1:0]    LAST_BEAT = LBW'(WORDS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LINE_ADDR_W-1:0] r_line;
    logic [LBW-1:0]         r_beat;
    logic [3:0]             r_lat_cnt;
    logic                   r_rd_valid;
    logic                   r_rd_last;

    logic                   w_accept;
    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic                   w_rd_en;
    logic [LBW-1:0]         w_rd_beat;
    logic                   w_lat_done;

    assign w_lat_done = (r_lat_cnt == 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_wr_ready  = 1'b0;
        o_wr_ack    = 1'b0;
        w_accept    = 1'b0;
        w_wr_fire   = 1'b0;
        w_rd_fire   = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_beat   = r_beat;
        case (r_state)
            IDLE: begin
                o_req_ready = !i_rst;
                w_accept    = i_req_valid && !i_rst;
                if (w_accept) begin
                    w_state_nxt = i_req_write ? WR_DATA : RD_WAIT;
                end
            end
            WR_DATA: begin
                o_wr_ready = !i_rst;
                w_wr_fire  = i_wr_valid && !i_rst;
                if (w_wr_fire && (r_beat == LAST_BEAT)) begin
                    w_state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (w_lat_done) begin
                    w_state_nxt = WR_ACK;
                end
            end
            WR_ACK: begin
                o_wr_ack    = !i_rst;
                w_state_nxt = IDLE;
            end
            RD_WAIT: begin
                // Fetch beat 0 one cycle early so it lands in the read register.
                if (w_lat_done) begin
                    w_state_nxt = RD_BURST;
                    w_rd_en     = 1'b1;
                    w_rd_beat   = '0;
                end
            end
            RD_BURST: begin
                w_rd_fire = r_rd_valid && i_rd_ready;
                if (w_rd_fire) begin
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_rd_en   = 1'b1;
                        w_rd_beat = r_beat + LBW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_line     <= '0;
            r_beat     <= '0;
            r_lat_cnt  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_line    <= i_req_line;
                r_beat    <= '0;
                r_lat_cnt <= LAT_LOAD;
            end
            if (w_wr_fire) begin
                r_beat <= r_beat + LBW'(1);
                if (r_beat == LAST_BEAT) begin
                    r_lat_cnt <= LAT_LOAD;
                end
            end
            if (((r_state == WR_WAIT) || (r_state == RD_WAIT)) && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if ((r_state == RD_WAIT) && w_lat_done) begin
                r_rd_valid <= 1'b1;
                r_rd_last  <= (WORDS == 1);
            end
            if (w_rd_fire) begin
                r_beat <= r_beat + LBW'(1);
                if (r_beat == LAST_BEAT) begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                end else begin
                    r_rd_last <= (w_rd_beat == LAST_BEAT);
                end
            end
        end
    end

    line_store #(
        .ADDR_W (ADDR_W),
        .WORD_W (DATA_W)
    ) u_line_store (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_fire),
        .i_wr_addr ({r_line, r_beat}),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr ({r_line, w_rd_beat}),
        .o_rd_data (o_rd_data)
    );

    assign o_rd_valid = r_rd_valid;
    assign o_rd_last  = r_rd_last;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed-plus-random bench for line_mem_responder against a word-addressed
// reference memory; drives a LATENCY=4 and a LATENCY=1 instance selected by sel.
module tb_line_mem_responder;

    localparam int WORDS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [12:0] req_line = '0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_ready = 1'b0;

    logic        rr4, wrr4, ack4, rv4, rl4;
    logic        rr1, wrr1, ack1, rv1, rl1;
    logic [31:0] rd4, rd1;

    logic        req_ready, wr_ready, wr_ack, rd_valid, rd_last;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    line_mem_responder #(.LINE_ADDR_W(13), .WORDS(16), .DATA_W(32), .LATENCY(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid & ~sel), .o_req_ready(rr4),
        .i_req_write(req_write), .i_req_line(req_line),
        .i_wr_valid(wr_valid & ~sel), .o_wr_ready(wrr4), .i_wr_data(wr_data),
        .o_wr_ack(ack4),
        .o_rd_valid(rv4), .i_rd_ready(rd_ready & ~sel), .o_rd_data(rd4), .o_rd_last(rl4)
    );

    line_mem_responder #(.LINE_ADDR_W(13), .WORDS(16), .DATA_W(32), .LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid & sel), .o_req_ready(rr1),
        .i_req_write(req_write), .i_req_line(req_line),
        .i_wr_valid(wr_valid & sel), .o_wr_ready(wrr1), .i_wr_data(wr_data),
        .o_wr_ack(ack1),
        .o_rd_valid(rv1), .i_rd_ready(rd_ready & sel), .o_rd_data(rd1), .o_rd_last(rl1)
    );

    assign req_ready = sel ? rr1  : rr4;
    assign wr_ready  = sel ? wrr1 : wrr4;
    assign wr_ack    = sel ? ack1 : ack4;
    assign rd_valid  = sel ? rv1  : rv4;
    assign rd_last   = sel ? rl1  : rl4;
    assign rd_data   = sel ? rd1  : rd4;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference memory: one word per {line, beat}, absent entries read as zero.
    bit [31:0] mem4 [int];
    bit [31:0] mem1 [int];

    function automatic bit [31:0] mref(input int line, input int beat);
        int k = line * WORDS + beat;
        if (sel) return mem1.exists(k) ? mem1[k] : 32'd0;
        return mem4.exists(k) ? mem4[k] : 32'd0;
    endfunction

    function automatic void mwrite(input int line, input int beat, input bit [31:0] d);
        int k = line * WORDS + beat;
        if (sel) mem1[k] = d;
        else     mem4[k] = d;
    endfunction

    function automatic int lat();
        return sel ? 1 : 4;
    endfunction

    logic [31:0] wdata [WORDS];
    int t_acc  = 0;
    int t_last = 0;

    task automatic fill_random();
        for (int i = 0; i < WORDS; i++) wdata[i] = $urandom;
    endtask

    task automatic issue_req(input logic wr, input int line);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_line  = 13'(line);
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        t_acc = cyc;
    endtask

    task automatic write_beats(input int line, input int nb, input bit gaps);
        int n = 0;
        int guard = 0;
        while (n < nb && guard < 400) begin
            wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_data  = wdata[n];
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                mwrite(line, n, wdata[n]);
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        wr_valid = 1'b0;
        t_last = cyc;
        check("wr_beats_done", 32'(n), 32'(nb));
    endtask

    task automatic wait_ack(input bit expect_ack);
        int pulses = 0;
        int tack = 0;
        logic rr_after = 1'b0;
        repeat (lat() + 4) begin
            @(negedge clk);
            if (pulses == 1 && cyc == tack + 1) rr_after = req_ready;
            if (wr_ack) begin
                pulses++;
                tack = cyc;
            end
            @(posedge clk); #1;
        end
        check("wr_ack_pulses", 32'(pulses), expect_ack ? 32'd1 : 32'd0);
        if (expect_ack) begin
            check("wr_ack_cycle", 32'(tack), 32'(t_last + lat()));
            check("req_ready_after_ack", 32'(rr_after), 32'd1);
        end
    endtask

    // mode 0: rd_ready held high; 1: pattern 1,0,0,1; 2: random
    task automatic read_burst(input int line, input int mode, input bit watch);
        int n = 0;
        int guard = 0;
        int k = 0;
        bit hold = 0;
        bit first = 1;
        bit saw_rr = 0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        int t0 = t_acc;
        while (n < WORDS && guard < 400) begin
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            @(negedge clk);
            if (watch && req_ready) saw_rr = 1;
            if (hold) begin
                check("rd_hold_valid", 32'(rd_valid), 32'd1);
                check("rd_hold_data", rd_data, hd);
                check("rd_hold_last", 32'(rd_last), 32'(hl));
                hold = 0;
            end
            if (rd_valid) begin
                if (first) begin
                    check("rd_first_valid_cycle", 32'(cyc), 32'(t0 + lat()));
                    first = 0;
                end
                if (rd_ready) begin
                    check("rd_data", rd_data, mref(line, n));
                    check("rd_last", 32'(rd_last), 32'(n == WORDS - 1));
                    if (mode == 0 && n == WORDS - 1)
                        check("rd_last_beat_cycle", 32'(cyc), 32'(t0 + lat() + WORDS - 1));
                    n++;
                end else begin
                    hold = 1;
                    hd = rd_data;
                    hl = rd_last;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        rd_ready = 1'b0;
        check("rd_beats_done", 32'(n), 32'(WORDS));
        @(negedge clk);
        check("rd_valid_after_burst", 32'(rd_valid), 32'd0);
        check("req_ready_after_burst", 32'(req_ready), 32'd1);
        if (watch) check("req_ignored_in_burst", 32'(saw_rr), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int rl;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Refill of an untouched line
        issue_req(1'b0, 'h0005);
        read_burst('h0005, 0, 0);

        // Write-back then refill with known pattern
        for (int i = 0; i < WORDS; i++) wdata[i] = 32'hA000_0000 + 32'(i);
        issue_req(1'b1, 'h1ABC);
        write_beats('h1ABC, WORDS, 1);
        wait_ack(1);
        issue_req(1'b0, 'h1ABC);
        read_burst('h1ABC, 0, 0);
        check("rb_word0_const", mref('h1ABC, 0), 32'hA000_0000);

        // Stalled refill while stray write beats are offered
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        issue_req(1'b0, 'h1ABC);
        wr_valid = 1'b1;
        read_burst('h1ABC, 1, 0);
        wr_valid = 1'b0;

        // Write request held during a read burst
        rl = int'($urandom_range(0, 8191));
        issue_req(1'b0, rl);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_line  = 13'h0002;
        read_burst(rl, 2, 1);
        req_valid = 1'b0;
        t_acc = cyc;
        fill_random();
        write_beats('h0002, WORDS, 1);
        wait_ack(1);
        issue_req(1'b0, 'h0002);
        read_burst('h0002, 2, 0);

        // Reset in the middle of a write-back
        fill_random();
        issue_req(1'b1, 'h0010);
        write_beats('h0010, WORDS, 0);
        wait_ack(1);
        fill_random();
        issue_req(1'b1, 'h0010);
        write_beats('h0010, 8, 0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst_wr_ready", 32'(wr_ready), 32'd0);
            check("midrst_req_ready", 32'(req_ready), 32'd0);
            check("midrst_wr_ack", 32'(wr_ack), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        wait_ack(0);
        issue_req(1'b0, 'h0010);
        read_burst('h0010, 0, 0);

        // Random write/read pairs
        repeat (3) begin
            rl = int'($urandom_range(0, 8191));
            fill_random();
            issue_req(1'b1, rl);
            write_beats(rl, WORDS, 1);
            wait_ack(1);
            issue_req(1'b0, rl);
            read_burst(rl, 2, 0);
        end

        // LATENCY=1 instance at the top line address
        sel = 1'b1;
        fill_random();
        issue_req(1'b1, 'h1FFF);
        write_beats('h1FFF, WORDS, 0);
        wait_ack(1);
        issue_req(1'b0, 'h1FFF);
        read_burst('h1FFF, 0, 0);
        issue_req(1'b0, 'h0000);
        read_burst('h0000, 0, 0);
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
